gate_sweep_checker: RTL and testbench
=====================================

// Module: gate_sweep_checker
// PURPOSE
//  Self-checking stimulus stage that sits directly upstream of the 2-input gate bank (and/or/xor/nand/nor/xnor).
//  On start it sweeps {A,B} through 00,01,10,11, waits a settle interval, and samples the six gate outputs.
//  Each sample is compared against the golden truth table; the block accumulates an error count and a per-gate fail mask.
//  It replaces the free-running $monitor benches with a synthesizable, repeatable go/no-go check.
// PARAMETERS
//  SETTLE_CYCLES  1    cycles {A,B} is held before sampling; legal range 1..255
//  PASSES         1    number of full 4-vector sweeps per start; legal range 1..255
// PORTS
//  clk        in   1  single clock; all state updates on rising edge
//  rst        in   1  synchronous, active-high reset
//  start      in   1  begin a run; sampled only in IDLE
//  A          out  1  stimulus to gate bank input A (registered)
//  B          out  1  stimulus to gate bank input B (registered)
//  gate_res   in   6  gate outputs: [0]=and [1]=or [2]=xor [3]=nand [4]=nor [5]=xnor
//  busy       out  1  high from the cycle after start is accepted until DONE
//  done       out  1  one-cycle pulse when the run completes
//  pass       out  1  high when the last completed run had err_count==0; held until next start
//  err_count  out  8  mismatching samples, saturates at 255
//  fail_mask  out  6  OR of (gate_res ^ expected) over all samples in the run
//  first_fail out  2  {A,B} of the first mismatching sample; 2'b00 if none
// BEHAVIOUR
//  Reset: state=IDLE, A=B=0, busy=done=pass=0, err_count=0, fail_mask=0, first_fail=0, vec=0, pass_cnt=0.
//  Golden table (gate_res, expected): {A,B}=00 -> 6'b111000; 01 -> 6'b001110; 10 -> 6'b001110; 11 -> 6'b100011.
//  FSM states: IDLE, SETTLE, SAMPLE, DONE.
//  IDLE: start=1 -> clear err_count, fail_mask, first_fail, and pass; vec=0, pass_cnt=0, {A,B}=00, busy=1.
//        Load settle_cnt=SETTLE_CYCLES-1 and go to SETTLE.
//  SETTLE: hold {A,B}; settle_cnt!=0 -> decrement; settle_cnt==0 -> SAMPLE.
//  SAMPLE (exactly 1 cycle): compare gate_res against golden[vec].
//        On mismatch, increment err_count (saturating at 255) and OR the difference into fail_mask.
//        On the first mismatch of the run, latch first_fail=vec.
//    vec!=3 -> vec+1, drive {A,B}=vec+1 on the same edge, reload settle_cnt, go to SETTLE.
//    vec==3 && pass_cnt!=PASSES-1 -> vec wraps to 0, pass_cnt+1, {A,B}=00, go to SETTLE.
//    vec==3 && pass_cnt==PASSES-1 -> go to DONE; pass=(err_count_next==0).
//  DONE: done=1 and busy=0 for one cycle; {A,B} returns to 00; next state is IDLE.
//  Per-vector cost is SETTLE_CYCLES+1 cycles. Run latency from the start edge to done high is 4*PASSES*(SETTLE_CYCLES+1)+1 edges.
//  start while busy or in DONE: ignored, with no restart and no effect on results.
//  Results (pass, err_count, fail_mask, first_fail) hold after DONE until the next accepted start or rst.
//  rst mid-run: the run is aborted immediately on that edge, all outputs take reset values, and no done pulse is issued.
//  Saturation: err_count stays at 255 once reached. fail_mask and first_fail continue to update normally.
//  gate_res is sampled only in SAMPLE; its value in other states is don't-care.
// STRUCTURE
//  Shared include gate_defs.vh:
//    - gate bit indices GATE_AND..GATE_XNOR (0..5)
//    - golden table constants EXP_00, EXP_01, EXP_10, EXP_11
//    - FSM state encodings
//  Sub-module gate_golden_rom: combinational 2-bit vec -> 6-bit expected. The bench reuses it as its reference model.
//  Top-level holds the FSM, settle counter, vec/pass counters, and result registers. There are no other sub-modules.
// TESTING
//  1. Gate bank correct, defaults, pulse start -> done after 9 edges; pass=1, err_count=0, fail_mask=0, A/B seq 00,01,10,11.
//  2. Inject and-output stuck-at-1 -> err_count=3, fail_mask=6'b000001, first_fail=2'b00, pass=0.
//  3. Swap xor/xnor wires, PASSES=2 -> err_count=8, fail_mask=6'b100100, first_fail=00.
//  4. SETTLE_CYCLES=3 -> each {A,B} held exactly 4 cycles, done at edge 17; pulse start mid-run -> no effect.
//  5. Assert rst during the vec=2 SETTLE -> next cycle busy=0, A=B=0, err_count=0, no done; a new start then runs clean.
//  6. gate_res forced 6'b000000, PASSES=100 -> err_count saturates at 255, fail_mask=6'b111111, done after 801 edges.

Source files
------------

// File: rtl/gate_sweep_checker_pkg.sv
// Shared definitions for the gate sweep checker: gate bit indices, golden
// truth-table rows, FSM state encoding and datapath widths.
package gate_sweep_checker_pkg;

   localparam int unsigned GATE_W = 6;
   localparam int unsigned VEC_W  = 2;
   localparam int unsigned CNT_W  = 8;

   localparam int unsigned GATE_AND  = 0;
   localparam int unsigned GATE_OR   = 1;
   localparam int unsigned GATE_XOR  = 2;
   localparam int unsigned GATE_NAND = 3;
   localparam int unsigned GATE_NOR  = 4;
   localparam int unsigned GATE_XNOR = 5;

   // Bit order {xnor, nor, nand, xor, or, and}
   localparam logic [GATE_W-1:0] EXP_00 = 6'b111000;
   localparam logic [GATE_W-1:0] EXP_01 = 6'b001110;
   localparam logic [GATE_W-1:0] EXP_10 = 6'b001110;
   localparam logic [GATE_W-1:0] EXP_11 = 6'b100011;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/gate_sweep_checker_golden_rom.sv
// Combinational golden truth table: stimulus vector {A,B} -> expected gate outputs.
module gate_sweep_checker_golden_rom
   import gate_sweep_checker_pkg::*;
(
   input  logic [VEC_W-1:0]  vec,
   output logic [GATE_W-1:0] expected_c
);

   always_comb begin
      expected_c = EXP_00;
      case (vec)
         2'b00:   expected_c = EXP_00;
         2'b01:   expected_c = EXP_01;
         2'b10:   expected_c = EXP_10;
         default: expected_c = EXP_11;
      endcase
   end

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweeps {A,B} through all four input combinations, samples the gate bank after a
// settle interval and accumulates error count, per-gate fail mask and first failing vector.
module gate_sweep_checker
   import gate_sweep_checker_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned PASSES        = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              A,
   output logic              B,
   input  logic [GATE_W-1:0] gate_res,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  err_count,
   output logic [GATE_W-1:0] fail_mask,
   output logic [VEC_W-1:0]  first_fail
);

   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] PASS_LAST   = CNT_W'(PASSES - 1);
   localparam logic [CNT_W-1:0] ERR_MAX     = {CNT_W{1'b1}};

   state_e             state;
   logic [CNT_W-1:0]   settle_cnt;
   logic [CNT_W-1:0]   pass_cnt;
   logic [VEC_W-1:0]   vec;

   logic [GATE_W-1:0]  expected_c;
   logic [GATE_W-1:0]  diff_c;
   logic               mismatch_c;
   logic [CNT_W-1:0]   err_next_c;

   gate_sweep_checker_golden_rom u_rom (
      .vec        (vec),
      .expected_c (expected_c)
   );

   // Compare current sample against golden; error count saturates
   always_comb begin
      diff_c     = gate_res ^ expected_c;
      mismatch_c = |diff_c;
      err_next_c = err_count;
      if (mismatch_c && (err_count != ERR_MAX)) begin
         err_next_c = err_count + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         A          <= 1'b0;
         B          <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_mask  <= '0;
         first_fail <= '0;
         vec        <= '0;
         pass_cnt   <= '0;
         settle_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  err_count  <= '0;
                  fail_mask  <= '0;
                  first_fail <= '0;
                  pass       <= 1'b0;
                  vec        <= '0;
                  pass_cnt   <= '0;
                  {A, B}     <= 2'b00;
                  busy       <= 1'b1;
                  settle_cnt <= SETTLE_LOAD;
                  state      <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt != '0) begin
                  settle_cnt <= settle_cnt - CNT_W'(1);
               end else begin
                  state <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               err_count <= err_next_c;
               if (mismatch_c) begin
                  fail_mask <= fail_mask | diff_c;
                  // An empty fail mask means no earlier mismatch in this run
                  if (fail_mask == '0) begin
                     first_fail <= vec;
                  end
               end
               if (vec != 2'b11) begin
                  vec        <= vec + VEC_W'(1);
                  {A, B}     <= vec + VEC_W'(1);
                  settle_cnt <= SETTLE_LOAD;
                  state      <= ST_SETTLE;
               end else if (pass_cnt != PASS_LAST) begin
                  vec        <= '0;
                  pass_cnt   <= pass_cnt + CNT_W'(1);
                  {A, B}     <= 2'b00;
                  settle_cnt <= SETTLE_LOAD;
                  state      <= ST_SETTLE;
               end else begin
                  {A, B} <= 2'b00;
                  pass   <= (err_next_c == '0);
                  state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Self-checking bench: three checker instances with different sweep parameters, each
// driven by a behavioural gate bank with configurable stuck-at and xor/xnor-swap faults.
module tb_gate_sweep_checker;

   localparam int S0 = 1, P0 = 1;
   localparam int S1 = 3, P1 = 2;
   localparam int S2 = 1, P2 = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       start [3];
   logic [5:0] gres  [3];
   logic       A [3], B [3], busy [3], done [3], pass [3];
   logic [7:0] errc  [3];
   logic [5:0] fmask [3];
   logic [1:0] ffail [3];

   logic [5:0] s0 [3];
   logic [5:0] s1 [3];
   logic       sw [3];

   int n_cmp = 0;
   int n_err = 0;

   int         lat;
   bit         timed_out;
   logic [1:0] ab_trace [$];

   gate_sweep_checker #(.SETTLE_CYCLES(S0), .PASSES(P0)) u_a (
      .clk(clk), .rst(rst), .start(start[0]), .A(A[0]), .B(B[0]), .gate_res(gres[0]),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errc[0]),
      .fail_mask(fmask[0]), .first_fail(ffail[0]));
   gate_sweep_checker #(.SETTLE_CYCLES(S1), .PASSES(P1)) u_b (
      .clk(clk), .rst(rst), .start(start[1]), .A(A[1]), .B(B[1]), .gate_res(gres[1]),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(errc[1]),
      .fail_mask(fmask[1]), .first_fail(ffail[1]));
   gate_sweep_checker #(.SETTLE_CYCLES(S2), .PASSES(P2)) u_c (
      .clk(clk), .rst(rst), .start(start[2]), .A(A[2]), .B(B[2]), .gate_res(gres[2]),
      .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(errc[2]),
      .fail_mask(fmask[2]), .first_fail(ffail[2]));

   // Gate bank with optional faults; with no faults it is the ideal boolean truth table
   function automatic logic [5:0] bank(input logic a, input logic b, input logic [5:0] st0,
                                       input logic [5:0] st1, input logic swp);
      logic [5:0] r;
      r = {~(a ^ b), ~(a | b), ~(a & b), a ^ b, a | b, a & b};
      if (swp) r = {r[2], r[4:3], r[5], r[1:0]};
      return (r | st1) & ~st0;
   endfunction

   always_comb begin
      for (int i = 0; i < 3; i++) gres[i] = bank(A[i], B[i], s0[i], s1[i], sw[i]);
   end

   function automatic int sett(input int i);
      return (i == 0) ? S0 : (i == 1) ? S1 : S2;
   endfunction

   function automatic int passes(input int i);
      return (i == 0) ? P0 : (i == 1) ? P1 : P2;
   endfunction

   // Expected results of one run: {pass, err_count, fail_mask, first_fail}
   function automatic logic [16:0] model(input int i);
      int         cnt;
      logic [5:0] m, obs, ex;
      logic [1:0] ff;
      bit         seen;
      cnt = 0; m = '0; ff = '0; seen = 0;
      for (int p = 0; p < passes(i); p++) begin
         for (int v = 0; v < 4; v++) begin
            obs = bank(v[1], v[0], s0[i], s1[i], sw[i]);
            ex  = bank(v[1], v[0], 6'h0, 6'h0, 1'b0);
            if (obs != ex) begin
               cnt++;
               m = m | (obs ^ ex);
               if (!seen) begin ff = 2'(v); seen = 1; end
            end
         end
      end
      return {cnt == 0, 8'((cnt > 255) ? 255 : cnt), m, ff};
   endfunction

   function automatic logic [16:0] results(input int i);
      return {pass[i], errc[i], fmask[i], ffail[i]};
   endfunction

   // Start a run on instance i and wait (bounded) for done; optional extra start pulse at pulse_at
   task automatic launch(input int i, input int max_cyc, input int pulse_at);
      @(negedge clk);
      start[i] = 1'b1;
      @(posedge clk); #1;
      start[i] = 1'b0;
      lat = 0; timed_out = 0;
      ab_trace.delete();
      ab_trace.push_back({A[i], B[i]});
      while (1) begin
         @(posedge clk); #1;
         lat++;
         start[i] = (lat == pulse_at);
         if (done[i]) break;
         if (lat >= max_cyc) begin timed_out = 1; break; end
         ab_trace.push_back({A[i], B[i]});
      end
      start[i] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({A[i], B[i], busy[i], done[i], results(i)} !== 21'h0) begin
            n_err++;
            $display("FAIL reset[%0d]: got %h want 0", i, {A[i], B[i], busy[i], done[i], results(i)});
         end
      end
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_clean();
      int lim;
      s0[0] = '0; s1[0] = '0; sw[0] = 0;
      launch(0, 50, 0);
      n_cmp++;
      if (timed_out !== 1'b0 || lat !== 9) begin
         n_err++; $display("FAIL clean_latency: got %0d (timeout %0d) want 9", lat, timed_out);
      end
      n_cmp++;
      if (results(0) !== {1'b1, 8'd0, 6'd0, 2'd0} || busy[0] !== 1'b0) begin
         n_err++; $display("FAIL clean_results: got %h busy %b want %h busy 0", results(0), busy[0], model(0));
      end
      lim = (ab_trace.size() < 8) ? ab_trace.size() : 8;
      for (int k = 0; k < 8; k++) begin
         n_cmp++;
         if (k >= lim || ab_trace[k] !== 2'(k / 2)) begin
            n_err++; $display("FAIL clean_ab[%0d]: got %b want %b", k, (k < lim) ? ab_trace[k] : 2'bxx, 2'(k / 2));
         end
      end
      @(posedge clk); #1;
      n_cmp++;
      if (done[0] !== 1'b0 || pass[0] !== 1'b1) begin
         n_err++; $display("FAIL done_pulse: got done %b pass %b want done 0 pass 1", done[0], pass[0]);
      end
   endtask

   task automatic test_stuck_and();
      s0[0] = '0; s1[0] = 6'b000001; sw[0] = 0;
      launch(0, 50, 0);
      n_cmp++;
      if (timed_out || results(0) !== {1'b0, 8'd3, 6'b000001, 2'b00} || results(0) !== model(0)) begin
         n_err++; $display("FAIL stuck_and: got %h want %h", results(0), {1'b0, 8'd3, 6'b000001, 2'b00});
      end
   endtask

   task automatic test_swap_and_ignored_start();
      int lim;
      s0[1] = '0; s1[1] = '0; sw[1] = 1;
      launch(1, 100, 5);
      n_cmp++;
      if (timed_out || lat !== 33) begin
         n_err++; $display("FAIL swap_latency: got %0d want 33", lat);
      end
      n_cmp++;
      if (results(1) !== {1'b0, 8'd8, 6'b100100, 2'b00}) begin
         n_err++; $display("FAIL swap_results: got %h want %h", results(1), {1'b0, 8'd8, 6'b100100, 2'b00});
      end
      lim = (ab_trace.size() < 32) ? ab_trace.size() : 32;
      for (int k = 0; k < 32; k++) begin
         n_cmp++;
         if (k >= lim || ab_trace[k] !== 2'((k / 4) % 4)) begin
            n_err++; $display("FAIL swap_ab[%0d]: got %b want %b", k, (k < lim) ? ab_trace[k] : 2'bxx, 2'((k / 4) % 4));
         end
      end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (busy[1] !== 1'b0) begin
         n_err++; $display("FAIL ignored_start_restart: got busy %b want 0", busy[1]);
      end
   endtask

   task automatic test_reset_midrun();
      int n_done;
      s0[0] = '0; s1[0] = 6'b000001; sw[0] = 0;
      @(negedge clk); start[0] = 1'b1;
      @(posedge clk); #1; start[0] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_cmp++;
      if ({busy[0], A[0], B[0], errc[0]} !== {3'b110, 8'd2}) begin
         n_err++; $display("FAIL pre_reset: got %h want %h", {busy[0], A[0], B[0], errc[0]}, {3'b110, 8'd2});
      end
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({A[0], B[0], busy[0], done[0], results(0)} !== 21'h0) begin
         n_err++; $display("FAIL midrun_reset: got %h want 0", {A[0], B[0], busy[0], done[0], results(0)});
      end
      @(negedge clk) rst = 1'b0;
      n_done = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done[0]) n_done++;
      end
      n_cmp++;
      if (n_done !== 0) begin
         n_err++; $display("FAIL no_done_after_reset: got %0d done pulses want 0", n_done);
      end
      s1[0] = '0;
      launch(0, 50, 0);
      n_cmp++;
      if (timed_out || lat !== 9 || results(0) !== {1'b1, 16'h0}) begin
         n_err++; $display("FAIL restart_clean: got lat %0d res %h want lat 9 res %h", lat, results(0), {1'b1, 16'h0});
      end
   endtask

   task automatic test_saturate();
      s0[2] = 6'b111111; s1[2] = '0; sw[2] = 0;
      launch(2, 1000, 0);
      n_cmp++;
      if (timed_out || lat !== 801) begin
         n_err++; $display("FAIL sat_latency: got %0d want 801", lat);
      end
      n_cmp++;
      if (results(2) !== {1'b0, 8'd255, 6'b111111, 2'b00}) begin
         n_err++; $display("FAIL sat_results: got %h want %h", results(2), {1'b0, 8'd255, 6'b111111, 2'b00});
      end
   endtask

   task automatic test_random();
      int i;
      logic [16:0] exp_r;
      for (int it = 0; it < 10; it++) begin
         i = $urandom_range(0, 1);
         s1[i] = 6'($urandom) & 6'($urandom);
         s0[i] = 6'($urandom) & 6'($urandom) & ~s1[i];
         sw[i] = ($urandom_range(0, 3) == 0);
         exp_r = model(i);
         launch(i, 200, 0);
         n_cmp++;
         if (timed_out || lat !== 4 * passes(i) * (sett(i) + 1) + 1 || results(i) !== exp_r) begin
            n_err++;
            $display("FAIL random[%0d] inst %0d: got lat %0d res %h want lat %0d res %h",
                     it, i, lat, results(i), 4 * passes(i) * (sett(i) + 1) + 1, exp_r);
         end
      end
   endtask

   // Second run launched in the very cycle done is high
   task automatic test_back_to_back();
      s0[0] = 6'b010000; s1[0] = '0; sw[0] = 0;
      launch(0, 50, 0);
      s0[0] = '0; s1[0] = 6'b000100;
      launch(0, 50, 0);
      n_cmp++;
      if (timed_out || lat !== 9 || results(0) !== model(0)) begin
         n_err++; $display("FAIL back_to_back: got lat %0d res %h want lat 9 res %h", lat, results(0), model(0));
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         start[i] = 1'b0; s0[i] = '0; s1[i] = '0; sw[i] = 1'b0;
      end
      test_reset();
      test_clean();
      test_stuck_and();
      test_swap_and_ignored_start();
      test_reset_midrun();
      test_saturate();
      test_random();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
